// File: rtl/ibr128_stream_adapter.sv
// Bridges a 32-bit word stream to a 128-bit block cipher core: gathers four words,
// pulses the core, waits a bounded time for the result and streams four words back out.
module ibr128_stream_adapter #(
  parameter int unsigned MSW_FIRST  = 1,
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         core_enable,
  output logic [127:0] core_plaintext,
  input  logic [127:0] core_ciphertext,
  input  logic         core_ready,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  block_count
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  // r_wcnt holds completed WAIT cycles, so the limit is hit one below WAIT_LIMIT
  localparam logic [15:0] LIMIT_M1 = 16'(WAIT_LIMIT - 1);

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_widx;
  logic [1:0]   r_oidx;
  logic [127:0] r_pt;
  logic [127:0] r_buf;
  logic [15:0]  r_wcnt;
  logic [15:0]  r_bcnt;
  logic         r_timeout;

  logic         w_in_hs;
  logic         w_out_hs;
  logic         w_capture;
  logic         w_expire;
  logic         w_limit;
  logic [1:0]   w_wslot;
  logic [1:0]   w_oslot;

  // Slot 3 is bits [127:96]; MSW-first ordering maps index k to slot 3-k
  assign w_wslot = (MSW_FIRST != 0) ? ~r_widx : r_widx;
  assign w_oslot = (MSW_FIRST != 0) ? ~r_oidx : r_oidx;
  assign w_limit = (r_wcnt == LIMIT_M1);

  assign out_data       = r_buf[{w_oslot, 5'b00000} +: 32];
  assign core_plaintext = r_pt;
  assign timeout_err    = r_timeout;
  assign block_count    = r_bcnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    core_enable = 1'b0;
    busy        = 1'b1;
    w_in_hs     = 1'b0;
    w_out_hs    = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_in_hs  = in_valid;
        if (in_valid && (r_widx == 2'd3)) begin
          w_next = S_START;
        end
      end
      S_START: begin
        core_enable = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the limit cycle still counts as success
        if (core_ready) begin
          w_capture = 1'b1;
          w_next    = S_DRAIN;
        end else if (w_limit) begin
          w_expire = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        w_out_hs  = out_ready;
        if (out_ready && (r_oidx == 2'd3)) begin
          w_next = S_LOAD;
        end
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_widx    <= '0;
      r_oidx    <= '0;
      r_pt      <= '0;
      r_buf     <= '0;
      r_wcnt    <= '0;
      r_bcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_pt[{w_wslot, 5'b00000} +: 32] <= in_data;
        r_widx                          <= r_widx + 2'd1;
      end
      if (r_state == S_START) begin
        r_wcnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
      if (w_capture) begin
        r_buf <= core_ciphertext;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
        r_widx    <= '0;
      end
      if (w_out_hs) begin
        r_oidx <= r_oidx + 2'd1;
        if (r_oidx == 2'd3) begin
          r_bcnt <= r_bcnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/ibr128_stream_adapter.md
IBR128_STREAM_ADAPTER -- requirements
Module: ibr128_stream_adapter

Interface
REQ-001 SHALL have parameter MSW_FIRST, default 1: 1 = first 32-bit word maps to bits [127:96]; 0 = first word maps to bits [31:0].
REQ-002 SHALL have parameter WAIT_LIMIT, default 1024: maximum WAIT cycles before timeout; legal range 2..65535.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 32 bits: plaintext word.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: adapter accepts a word this cycle.
REQ-008 SHALL have port out_data, output, 32 bits: ciphertext word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: sink accepts out_data.
REQ-011 SHALL have port core_enable, output, 1 bit: one-cycle start pulse to the cipher core Enable input.
REQ-012 SHALL have port core_plaintext, output, 128 bits: driven to the core plainText input.
REQ-013 SHALL have port core_ciphertext, input, 128 bits: from the core cipherText output.
REQ-014 SHALL have port core_ready, input, 1 bit: from the core cipherReady output.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than LOAD.
REQ-016 SHALL have port timeout_err, output, 1 bit: sticky error flag.
REQ-017 SHALL have port block_count, output, 16 bits: count of blocks fully drained.

Function
REQ-018 SHALL implement the FSM states LOAD, START, WAIT and DRAIN.
REQ-019 LOAD: in_ready=1; each in_valid&in_ready handshake SHALL write in_data into the word slot selected by the 2-bit word index, then increment the index.
REQ-020 The 4th LOAD handshake SHALL move the FSM to START next cycle; the index SHALL wrap to 0.
REQ-021 START: core_enable=1 for exactly one cycle, in_ready=0; the FSM SHALL then move to WAIT.
REQ-022 core_plaintext SHALL be registered and held stable from the 4th accept until the first accept of the next block.
REQ-023 WAIT: core_ready SHALL be sampled only in WAIT; in START it SHALL be ignored. When core_ready=1, core_ciphertext SHALL be captured into the output buffer and the FSM SHALL move to DRAIN.
REQ-024 WAIT: a 16-bit cycle counter SHALL be cleared on entry and increment each cycle. If it reaches WAIT_LIMIT with core_ready=0, timeout_err SHALL be set, the block SHALL be discarded and the FSM SHALL return to LOAD with index 0; block_count is unchanged.
REQ-025 If core_ready=1 in the same cycle the limit is reached, capture SHALL win and timeout_err SHALL NOT be set.
REQ-026 DRAIN: out_valid=1 and out_data = buffer word at the output index, using the same MSW_FIRST ordering as input; the index SHALL advance on each out_valid&out_ready handshake.
REQ-027 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 The 4th DRAIN handshake SHALL increment block_count (wraps 0xFFFF->0x0000) and return the FSM to LOAD; in_ready SHALL rise the following cycle, with no overlap with draining.
REQ-029 in_valid outside LOAD SHALL be ignored; no word is consumed.
REQ-030 timeout_err SHALL clear only on Rst.
REQ-031 Latency from the 4th input accept to first out_valid SHALL be 3 cycles plus core latency: START 1 cycle, a minimum of 1 WAIT cycle, capture edge.

Reset
REQ-032 On Rst=1 at a clock edge: FSM=LOAD, word/output indices=0, in_ready=1 the following cycle.
REQ-033 On Rst=1 at a clock edge: out_valid=0, core_enable=0, busy=0, timeout_err=0, block_count=0, core_plaintext=0, output buffer=0.
REQ-034 Rst SHALL take priority over all handshakes in the same cycle; reset in any state SHALL abort the block with no partial output.

Verification
REQ-035 Single block, MSW_FIRST=1: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> core_plaintext=0x00112233_44556677_8899AABB_CCDDEEFF; core_enable high exactly 1 cycle; model core returns the value XOR all-ones after 10 cycles -> out words 0xFFEEDDCC, 0xBBAA9988, 0x77665544, 0x33221100; block_count=1.
REQ-036 Backpressure: out_ready toggles 1,0,0,1 -> each word held stable while stalled; exactly 4 handshakes, no duplicates or drops; in_ready=0 throughout DRAIN.
REQ-037 Timeout, WAIT_LIMIT=8: core_ready never asserted -> timeout_err=1 after 8 WAIT cycles; FSM returns to LOAD; block_count unchanged; the next block completes normally with timeout_err still 1.
REQ-038 Boundary: core_ready asserted on the exact limit cycle -> capture occurs and timeout_err stays 0.
REQ-039 Reset mid-operation: Rst after 2 accepted words, then Rst in DRAIN after 1 output word -> all outputs return to reset values; the next 4 words form a fresh block starting at index 0.
REQ-040 Counter wrap: preload via 65536 blocks, or force block_count=0xFFFF -> the next completed block gives 0x0000; MSW_FIRST=0 run with the same data gives reversed word placement.
